game_ctrl: RTL and testbench

- Round sequencer for the air-hockey game datapath: ball motion, paddle collision and miss flash.
- Decides when the ball is frozen, re-served or free-running. Counts paddle hits as a 2-digit BCD score and tracks remaining lives.
- Sits between the button inputs and the ball/collision logic. All timing is counted in video frames via the end-of-frame strobe.

---
 rtl/game_ctrl.sv | 129 ++++++++++++
 tb/tb_game_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Air-hockey round sequencer: serve hold, free play, miss flash and game over,
// with a saturating 2-digit BCD hit score and a lives counter.
module game_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       end_of_frame,
    input  logic       btn_start,
    input  logic       hit,
    input  logic       miss,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic       miss_flash,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [2:0] state
);

    // state | meaning
    // IDLE  | waiting for the first start press, ball frozen
    // SERVE | ball held at serve position for SERVE_FRAMES frames
    // PLAY  | ball free-running, hits scored, miss ends the rally
    // MISS  | miss flash for MISS_FRAMES frames
    // OVER  | no lives left, score held until the next start press
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_MISS  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [5:0] SERVE_LOAD = 6'(SERVE_FRAMES);
    localparam logic [5:0] MISS_LOAD  = 6'(MISS_FRAMES);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES);

    logic       btn_start_q;
    logic [5:0] timer;
    logic       start_rise;
    logic       timer_last;
    logic [7:0] score_inc;

    assign start_rise = btn_start & ~btn_start_q;
    assign timer_last = end_of_frame && (timer == 6'd1);

    always_comb begin
        score_inc = score;
        if (score == 8'h99)
            score_inc = score;
        else if (score[3:0] == 4'd9)
            score_inc = {score[7:4] + 4'd1, 4'd0};
        else
            score_inc = {score[7:4], score[3:0] + 4'd1};
    end

    // Sampled through reset as well, so a button held across reset release
    // must be let go and pressed again before it counts as a start.
    always_ff @(posedge clk) begin
        btn_start_q <= btn_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ball_enable <= 1'b0;
            ball_reset  <= 1'b0;
            miss_flash  <= 1'b0;
            score       <= 8'h00;
            lives       <= LIVES_LOAD;
            timer       <= 6'd0;
        end else begin
            ball_reset <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    ball_enable <= 1'b0;
                    if (start_rise) begin
                        state      <= S_SERVE;
                        score      <= 8'h00;
                        lives      <= LIVES_LOAD;
                        timer      <= SERVE_LOAD;
                        ball_reset <= 1'b1;
                    end
                end
                S_SERVE: begin
                    if (end_of_frame && timer != 6'd0)
                        timer <= timer - 6'd1;
                    if (timer_last) begin
                        state       <= S_PLAY;
                        ball_enable <= 1'b1;
                    end
                end
                S_PLAY: begin
                    // A miss outranks a simultaneous hit and reloads the timer
                    // even when the frame strobe coincides.
                    if (miss) begin
                        state       <= S_MISS;
                        lives       <= lives - 2'd1;
                        timer       <= MISS_LOAD;
                        ball_enable <= 1'b0;
                        miss_flash  <= 1'b1;
                    end else if (hit) begin
                        score <= score_inc;
                    end
                end
                S_MISS: begin
                    if (end_of_frame && timer != 6'd0)
                        timer <= timer - 6'd1;
                    if (timer_last) begin
                        miss_flash <= 1'b0;
                        if (lives == 2'd0) begin
                            state <= S_OVER;
                        end else begin
                            state      <= S_SERVE;
                            timer      <= SERVE_LOAD;
                            ball_reset <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    ball_enable <= 1'b0;
                    miss_flash  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: each stimulus cycle queues the expected
// post-edge outputs; a monitor pops and compares one entry per clock.
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       end_of_frame = 1'b0;
    logic       btn_start = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       ball_enable;
    logic       ball_reset;
    logic       miss_flash;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] state;

    game_ctrl #(.LIVES(3), .SERVE_FRAMES(60), .MISS_FRAMES(63)) dut (
        .clk(clk), .rst(rst), .end_of_frame(end_of_frame), .btn_start(btn_start),
        .hit(hit), .miss(miss), .ball_enable(ball_enable), .ball_reset(ball_reset),
        .miss_flash(miss_flash), .score(score), .lives(lives), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic       en;
        logic       br;
        logic       mf;
        logic [7:0] sc;
        logic [1:0] lv;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    logic [2:0] e_st = 3'd0;
    logic       e_en = 1'b0;
    logic       e_br = 1'b0;
    logic       e_mf = 1'b0;
    logic [7:0] e_sc = 8'h00;
    logic [1:0] e_lv = 2'd3;

    function automatic logic [7:0] bcd_next(input logic [7:0] s);
        int v;
        v = int'(s[7:4]) * 10 + int'(s[3:0]);
        if (v < 99) v = v + 1;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Inputs are applied after a falling edge; the entry describes the
    // outputs expected just after the following rising edge.
    task automatic step(input logic eof, input logic st, input logic h,
                        input logic m, input logic r, input string tag);
        exp_t e;
        end_of_frame = eof;
        btn_start    = st;
        hit          = h;
        miss         = m;
        rst          = r;
        e.st = e_st; e.en = e_en; e.br = e_br; e.mf = e_mf; e.sc = e_sc; e.lv = e_lv;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        e_br = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_game();
        e_st = 3'd1; e_en = 1'b0; e_mf = 1'b0; e_sc = 8'h00; e_lv = 2'd3; e_br = 1'b1;
        step(0, 1, 0, 0, 0, "start_rise");
        step(0, 0, 0, 0, 0, "start_release");
    endtask

    task automatic serve_to_play();
        for (int i = 1; i <= 60; i++) begin
            if (i == 60) begin
                e_st = 3'd2; e_en = 1'b1;
            end
            step(1, 0, 0, 0, 0, "serve_frames");
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            e_sc = bcd_next(e_sc);
            step(0, 0, 1, 0, 0, "hit_score");
        end
    endtask

    task automatic take_miss(input logic h);
        e_st = 3'd3; e_en = 1'b0; e_mf = 1'b1; e_lv = e_lv - 2'd1;
        step(0, 0, h, 1, 0, "miss_taken");
    endtask

    task automatic miss_frames();
        for (int i = 1; i <= 63; i++) begin
            if (i == 63) begin
                e_mf = 1'b0;
                if (e_lv == 2'd0) begin
                    e_st = 3'd4;
                end else begin
                    e_st = 3'd1; e_br = 1'b1;
                end
            end
            step(1, 0, 0, 0, 0, "miss_frames");
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_vec++;
                if (state !== e.st || ball_enable !== e.en || ball_reset !== e.br ||
                    miss_flash !== e.mf || score !== e.sc || lives !== e.lv) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got st=%0d en=%b br=%b mf=%b score=%h lives=%0d, want st=%0d en=%b br=%b mf=%b score=%h lives=%0d",
                             t, $time, state, ball_enable, ball_reset, miss_flash, score, lives,
                             e.st, e.en, e.br, e.mf, e.sc, e.lv);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        @(negedge clk);
        step(0, 0, 0, 0, 1, "reset");
        step(0, 0, 0, 0, 0, "idle_hold");
        step(0, 0, 1, 1, 0, "idle_ignores_events");

        // Game A: scoring, saturation, three misses to game over.
        start_game();
        for (int i = 1; i <= 59; i++) step(1, 0, 0, 0, 0, "serve_59");
        step(0, 0, 0, 0, 0, "serve_after_59");
        e_st = 3'd2; e_en = 1'b1;
        step(1, 0, 0, 0, 0, "serve_60th");
        hits(8);
        hits(2);
        hits(88);
        hits(3);
        step(1, 0, 0, 0, 0, "play_eof");
        e_st = 3'd3; e_en = 1'b0; e_mf = 1'b1; e_lv = 2'd2;
        step(1, 0, 0, 1, 0, "miss_with_eof");
        step(0, 0, 1, 0, 0, "miss_ignores_hit");
        step(0, 1, 0, 0, 0, "miss_ignores_start");
        step(0, 0, 0, 0, 0, "miss_start_release");
        miss_frames();
        serve_to_play();
        take_miss(1'b0);
        miss_frames();
        serve_to_play();
        take_miss(1'b0);
        miss_frames();
        step(0, 0, 1, 0, 0, "over_ignores_hit");
        step(1, 0, 1, 1, 0, "over_ignores_events");
        start_game();

        // Game B: hit/miss tie, then reset mid-play with start held.
        step(0, 0, 1, 0, 0, "serve_ignores_hit");
        step(0, 0, 0, 1, 0, "serve_ignores_miss");
        serve_to_play();
        hits(5);
        take_miss(1'b1);
        miss_frames();
        serve_to_play();
        hits(42);
        step(0, 1, 0, 0, 0, "play_ignores_start");
        e_st = 3'd0; e_en = 1'b0; e_mf = 1'b0; e_sc = 8'h00; e_lv = 2'd3;
        step(0, 1, 0, 0, 1, "reset_mid_play");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, "held_start_no_game");
        step(0, 0, 0, 0, 0, "start_dropped");
        start_game();

        step(0, 0, 0, 0, 0, "drain");
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
